// File: rtl/write_back_reg.sv
// Write-back stage register: picks the result source, extracts and extends load data,
// and drives the register-file write port and the retired-instruction counter.
module write_back_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [1:0]        wb_sel,
   input  logic [1:0]        load_size,
   input  logic              load_unsigned,
   input  logic [1:0]        byte_off,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] ex_data,
   input  logic [DATA_W-1:0] link_data,
   input  logic [DATA_W-1:0] imm_data,
   input  logic              reg_write_in,
   input  logic [REG_AW-1:0] rd_in,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              wb_valid,
   output logic [CNT_W-1:0]  retire_count
);

   function automatic logic [DATA_W-1:0] load_extract(
      input logic [DATA_W-1:0] data,
      input logic [1:0]        size,
      input logic              uns,
      input logic [1:0]        off
   );
      logic [7:0]        byte_s;
      logic [15:0]       half_s;
      logic [DATA_W-1:0] res_s;
      case (off)
         2'd0:    byte_s = data[7:0];
         2'd1:    byte_s = data[15:8];
         2'd2:    byte_s = data[23:16];
         2'd3:    byte_s = data[31:24];
         default: byte_s = data[7:0];
      endcase
      if (off[1]) begin
         half_s = data[31:16];
      end else begin
         half_s = data[15:0];
      end
      // load_size 2'b11 falls into the word path
      case (size)
         2'b01:   res_s = {{(DATA_W-16){half_s[15] & ~uns}}, half_s};
         2'b10:   res_s = {{(DATA_W-8){byte_s[7] & ~uns}}, byte_s};
         default: res_s = data;
      endcase
      return res_s;
   endfunction

   logic              valid_q, valid_d;
   logic              reg_write_q, reg_write_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] load_s;
   logic [DATA_W-1:0] sel_s;

   // Result source selection, including the extracted load value
   always_comb begin
      load_s = load_extract(mem_data, load_size, load_unsigned, byte_off);
      sel_s  = ex_data;
      case (wb_sel)
         2'b00:   sel_s = ex_data;
         2'b01:   sel_s = load_s;
         2'b10:   sel_s = link_data;
         2'b11:   sel_s = imm_data;
         default: sel_s = ex_data;
      endcase
   end

   // Stage capture: flush beats stall, stall holds, otherwise load the MEM slot
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      rd_d        = rd_q;
      data_d      = data_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
      end else if (stall) begin
         valid_d     = valid_q;
         reg_write_d = reg_write_q;
      end else begin
         valid_d     = in_valid;
         reg_write_d = reg_write_in;
         rd_d        = rd_in;
         data_d      = sel_s;
      end
   end

   // Retire counter: an instruction retires on the edge it leaves an unstalled stage
   always_comb begin
      cnt_d = cnt_q;
      if (valid_q && !stall) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stage and counter state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_q        <= {REG_AW{1'b0}};
         data_q      <= {DATA_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         rd_q        <= rd_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
      end
   end

   // Stall gating keeps a held instruction from writing more than once
   assign rf_we        = valid_q & reg_write_q & (rd_q != {REG_AW{1'b0}}) & ~stall;
   assign rf_waddr     = rd_q;
   assign rf_wdata     = data_q;
   assign wb_valid     = valid_q;
   assign retire_count = cnt_q;

endmodule

// File: doc/write_back_reg.md
WRITE_BACK_REG -- requirements
Module: write_back_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width in bits; legal values are multiples of 8 and at least 32.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning register-file address width.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning retire-counter width.
REQ-004 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid  in  1  incoming MEM-stage slot holds a real instruction.
REQ-007 The block SHALL have port stall  in  1  hold the stage register.
REQ-008 The block SHALL have port flush  in  1  replace the incoming slot with a bubble.
REQ-009 The block SHALL have port wb_sel  in  2  source select: 00 ex_data, 01 extracted load, 10 link_data, 11 imm_data.
REQ-010 The block SHALL have port load_size  in  2  load size: 00 word, 01 half, 10 byte; 11 is treated as word.
REQ-011 The block SHALL have port load_unsigned  in  1  1 selects zero-extension, 0 selects sign-extension.
REQ-012 The block SHALL have port byte_off  in  2  load address bits [1:0].
REQ-013 The block SHALL have ports mem_data, ex_data, link_data, imm_data  in  DATA_W  candidate results.
REQ-014 The block SHALL have port reg_write_in  in  1  the instruction writes the register file.
REQ-015 The block SHALL have port rd_in  in  REG_AW  destination register.
REQ-016 The block SHALL have port rf_we  out  1  register-file write enable.
REQ-017 The block SHALL have port rf_waddr  out  REG_AW  register-file write address.
REQ-018 The block SHALL have port rf_wdata  out  DATA_W  register-file write data; also used as the forwarding source.
REQ-019 The block SHALL have port wb_valid  out  1  the stage holds a real instruction.
REQ-020 The block SHALL have port retire_count  out  CNT_W  number of instructions retired.

Function
REQ-021 Load extraction SHALL be combinational on the inputs: byte = mem_data[8*byte_off +: 8]; half = mem_data[16*byte_off[1] +: 16], with byte_off[0] ignored.
REQ-022 Byte and half results SHALL be sign- or zero-extended to DATA_W per load_unsigned; a word load SHALL pass mem_data unchanged.
REQ-023 Source selection per wb_sel SHALL be combinational, and the selected value SHALL be captured into the stage register.
REQ-024 Latency SHALL be one cycle: inputs presented before rising edge N appear on the outputs after edge N.
REQ-025 Capture rule per edge, in priority order:
- flush=1 -> load a bubble (valid=0, reg_write=0, data and address unchanged).
- else stall=1 -> hold all stage state.
- else -> load in_valid, reg_write_in, rd_in and the selected data.
REQ-026 When flush and stall are both 1 on the same edge, flush SHALL win.
REQ-027 rf_we SHALL equal stored valid AND stored reg_write AND (stored rd != 0); register 0 is never written.
REQ-028 During a stall, rf_we SHALL be forced to 0 so the held instruction writes exactly once.
REQ-029 rf_waddr and rf_wdata SHALL show the stored values regardless of rf_we.
REQ-030 wb_valid SHALL equal the stored valid bit.
REQ-031 retire_count SHALL increment by 1 on each edge where the stage holds valid=1 and stall=0.
REQ-032 retire_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-033 Bubbles SHALL never increment retire_count.

Reset
REQ-034 While reset=1, asynchronously and regardless of clk, all outputs SHALL be 0: rf_we, rf_waddr, rf_wdata, wb_valid, retire_count.
REQ-035 Reset asserted mid-operation SHALL discard the held instruction, which is not written or counted.
REQ-036 After reset deasserts, the first capture SHALL occur on the next rising edge without stall or flush.

Verification
REQ-037 Byte load: wb_sel=01, load_size=10, load_unsigned=0, byte_off=2, mem_data=0x1280_FF34, rd_in=7, reg_write_in=1, in_valid=1 -> after one edge: rf_we=1, rf_waddr=7, rf_wdata=0xFFFF_FF80; with load_unsigned=1 -> 0x0000_0080.
REQ-038 Half load: load_size=01, byte_off=3, mem_data=0x8001_1234, load_unsigned=0 -> rf_wdata=0xFFFF_8001.
REQ-039 Stall and flush: valid instruction captured, then stall=1 for 3 cycles -> outputs held, rf_we=0 during the stall, retire_count incremented once in total; flush=1 together with stall=1 -> wb_valid=0 next cycle.
REQ-040 Register zero: rd_in=0, reg_write_in=1, wb_sel=00, ex_data=0xDEAD_BEEF -> rf_we=0, rf_wdata=0xDEAD_BEEF, retire_count incremented.
REQ-041 Counter wrap: CNT_W=4, 17 back-to-back valid non-stalled instructions -> retire_count reads 1.
REQ-042 Reset mid-stall: reset asserted between edges while a valid instruction is held -> all outputs 0 immediately, and the instruction is never written.
